// File: rtl/hilo_muldiv.sv
// HI/LO register pair with the mult/div group for the execute stage.
// Multiplies and HI/LO moves commit in one cycle; divides run on a
// 32-step restoring divider that holds the pipeline through div_stall.
module hilo_muldiv #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   HILO_RST = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       alucontrolE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             validE,
    input  logic             flushE,
    input  logic             stallE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] mfresultE,
    output logic             div_stall
);

    // Operation codes shared with the decode-stage ALU decoder.
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_t;

    div_state_t       state, state_nxt;
    logic             stall_raw;
    logic             div_start;
    logic             div_write;
    logic             commit;
    logic             is_div_op;
    logic             is_signed_div;

    logic [WIDTH-1:0] hi, lo;

    // Divider datapath: quo shifts the dividend out and the quotient in.
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_shift;
    logic [WIDTH:0]   step_diff;
    logic             step_ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] q_res, r_res;

    logic             mul_signed;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;

    assign is_div_op     = (alucontrolE == EXE_DIV_OP) || (alucontrolE == EXE_DIVU_OP);
    assign is_signed_div = (alucontrolE == EXE_DIV_OP);
    assign commit        = validE & ~flushE & ~stallE & ~div_stall;

    // The stall is forced low while reset is held so the pipeline is released
    // immediately, even if E still shows a divide.
    assign div_stall = stall_raw & resetn;

    // Operand magnitudes for the unsigned core; DIVU uses raw values.
    assign a_mag = (is_signed_div & srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
    assign b_mag = (is_signed_div & srcbE[WIDTH-1]) ? (~srcbE + 1'b1) : srcbE;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign step_shift = {rem, quo[WIDTH-1]};
    assign step_diff  = step_shift - {1'b0, divisor};
    assign step_ge    = (step_shift >= {1'b0, divisor});
    assign step_rem   = step_ge ? step_diff[WIDTH-1:0] : step_shift[WIDTH-1:0];

    // Sign correction of the finished magnitudes.
    assign q_res = neg_q ? (~quo + 1'b1) : quo;
    assign r_res = neg_r ? (~rem + 1'b1) : rem;

    // Low 2*WIDTH bits of the extended product equal the signed or unsigned product.
    assign mul_signed = (alucontrolE == EXE_MULT_OP);
    assign mul_a      = {{WIDTH{mul_signed & srcaE[WIDTH-1]}}, srcaE};
    assign mul_b      = {{WIDTH{mul_signed & srcbE[WIDTH-1]}}, srcbE};
    assign product    = mul_a * mul_b;

    // Divider state register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Divider next-state, stall and result-write decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_nxt = state;
        stall_raw = 1'b0;
        div_start = 1'b0;
        div_write = 1'b0;
        case (state)
            S_IDLE: begin
                if (validE & ~flushE & is_div_op) begin
                    stall_raw = 1'b1;
                    div_start = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_raw = 1'b1;
                if (flushE) begin
                    state_nxt = S_IDLE;
                end else if (count == CNT_MAX) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (flushE) begin
                    state_nxt = S_IDLE;
                end else if (!stallE) begin
                    div_write = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divider datapath: latch operands on accept, then one step per BUSY cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (div_start) begin
            count   <= '0;
            quo     <= a_mag;
            rem     <= '0;
            divisor <= b_mag;
            // A zero divisor leaves an all-ones quotient and the dividend
            // magnitude as remainder; suppressing the quotient negation and
            // re-applying the dividend sign yields LO=all-ones, HI=srcaE.
            neg_q   <= is_signed_div & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]) & (srcbE != '0);
            neg_r   <= is_signed_div & srcaE[WIDTH-1];
        end else if ((state == S_BUSY) && !flushE) begin
            count <= count + 1'b1;
            quo   <= {quo[WIDTH-2:0], step_ge};
            rem   <= step_rem;
        end
    end

    // HI/LO update: divide results from DONE, otherwise single-cycle ops on commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= HILO_RST;
            lo <= HILO_RST;
        end else if (div_write) begin
            hi <= r_res;
            lo <= q_res;
        end else if (commit) begin
            case (alucontrolE)
                EXE_MULT_OP, EXE_MULTU_OP: {hi, lo} <= product;
                EXE_MTHI_OP:               hi <= srcaE;
                EXE_MTLO_OP:               lo <= srcaE;
                default: ;
            endcase
        end
    end

    // Move-from result for the E-stage result mux.
    always_comb begin
        mfresultE = '0;
        if (alucontrolE == EXE_MFHI_OP) begin
            mfresultE = hi;
        end else if (alucontrolE == EXE_MFLO_OP) begin
            mfresultE = lo;
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule
